// File: rtl/operand_fetch.sv
// Operand fetch: 32x32 register file (r0 hardwired to 0) with write-through bypass, feeding a registered ALU operand stage.
// One cycle from accepted instruction to valid_o; stall_i holds the stage (ready_o = !stall_i), flush_i clears it even while stalled.
module operand_fetch #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              alu_src_i,
  input  logic [3:0]        alu_ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [3:0]        ctrl_o,
  output logic              valid_o,
  output logic              ready_o
);

  logic [DATA_W-1:0] r_regs [32];
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic [3:0]        r_ctrl;
  logic              r_valid;

  logic              w_wb_en;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_src2;

  assign w_wb_en = wb_we_i && (wb_addr_i != 5'd0);

  // Same-cycle write-back wins over the stored value so back-to-back producers need no stall.
  always_comb begin
    w_rs_val = r_regs[rs_addr_i];
    if (rs_addr_i == 5'd0) begin
      w_rs_val = '0;
    end else if (w_wb_en && (wb_addr_i == rs_addr_i)) begin
      w_rs_val = wb_data_i;
    end
  end

  always_comb begin
    w_rt_val = r_regs[rt_addr_i];
    if (rt_addr_i == 5'd0) begin
      w_rt_val = '0;
    end else if (w_wb_en && (wb_addr_i == rt_addr_i)) begin
      w_rt_val = wb_data_i;
    end
  end

  assign w_src2 = alu_src_i ? imm_i : w_rt_val;

  // Write-back ignores stall/flush; only reset blocks it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[wb_addr_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_src1  <= '0;
      r_src2  <= '0;
      r_ctrl  <= 4'd0;
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      if (valid_i) begin
        r_src1  <= w_rs_val;
        r_src2  <= w_src2;
        r_ctrl  <= alu_ctrl_i;
        r_valid <= 1'b1;
      end else begin
        r_src1  <= '0;
        r_src2  <= '0;
        r_ctrl  <= 4'd0;
        r_valid <= 1'b0;
      end
    end
  end

  assign src1_o  = r_src1;
  assign src2_o  = r_src2;
  assign ctrl_o  = r_ctrl;
  assign valid_o = r_valid;
  assign ready_o = !stall_i;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomised bench for operand_fetch against a register-array reference model.
module tb_operand_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, alu_src_i, stall_i, flush_i, wb_we_i;
  logic [4:0]  rs_addr_i, rt_addr_i, wb_addr_i;
  logic [31:0] imm_i, wb_data_i;
  logic [3:0]  alu_ctrl_i;
  logic [31:0] src1_o, src2_o;
  logic [3:0]  ctrl_o;
  logic        valid_o, ready_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_src1, m_src2;
  logic [3:0]  m_ctrl;
  logic        m_vld;

  operand_fetch #(.DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .imm_i(imm_i),
    .alu_src_i(alu_src_i), .alu_ctrl_i(alu_ctrl_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o),
    .valid_o(valid_o), .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_we_i && wb_addr_i == idx) return wb_data_i;
    return m_regs[idx];
  endfunction

  // Advance the model by one edge using the inputs currently applied, then move to the next falling edge.
  task automatic tick();
    logic [31:0] a, b;
    a = model_read(rs_addr_i);
    b = alu_src_i ? imm_i : model_read(rt_addr_i);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_src1 = 0; m_src2 = 0; m_ctrl = 0; m_vld = 0;
    end else begin
      if (wb_we_i && wb_addr_i != 5'd0) m_regs[wb_addr_i] = wb_data_i;
      if (flush_i) begin
        m_src1 = 0; m_src2 = 0; m_ctrl = 0; m_vld = 0;
      end else if (!stall_i) begin
        if (valid_i) begin
          m_src1 = a; m_src2 = b; m_ctrl = alu_ctrl_i; m_vld = 1;
        end else begin
          m_src1 = 0; m_src2 = 0; m_ctrl = 0; m_vld = 0;
        end
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    rst_i = 0; valid_i = 0; alu_src_i = 0; stall_i = 0; flush_i = 0; wb_we_i = 0;
    rs_addr_i = 0; rt_addr_i = 0; wb_addr_i = 0; imm_i = 0; wb_data_i = 0; alu_ctrl_i = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic src,
                       input logic [31:0] imm, input logic [3:0] ctrl);
    valid_i = 1; rs_addr_i = rs; rt_addr_i = rt; alu_src_i = src; imm_i = imm; alu_ctrl_i = ctrl;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1; valid_i = 1; rs_addr_i = 3; wb_we_i = 1; wb_addr_i = 3; wb_data_i = 32'h55;
    tick();
    checks++;
    if (src1_o !== 32'h0 || src2_o !== 32'h0 || ctrl_o !== 4'h0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %h %b, want 0 0 0 0", src1_o, src2_o, ctrl_o, valid_o);
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      issue(i[4:0], i[4:0], 1'b0, 32'h0, 4'h0);
      tick();
      checks++;
      if (src1_o !== 32'h0 || src2_o !== 32'h0 || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_reg r%0d: got %h %h vld %b, want 0 0 vld 1", i, src1_o, src2_o, valid_o);
      end
    end
    idle();
    wb_we_i = 1; wb_addr_i = 0; wb_data_i = 32'hFFFF_FFFF;
    tick();
    idle();
    issue(5'd0, 5'd0, 1'b0, 32'h0, 4'h0);
    tick();
    checks++;
    if (src1_o !== 32'h0 || src2_o !== 32'h0) begin
      errors++;
      $display("FAIL r0_write: got %h %h, want 0 0", src1_o, src2_o);
    end
  endtask

  task automatic test_basic();
    idle();
    wb_we_i = 1; wb_addr_i = 5; wb_data_i = 32'hA;
    tick();
    idle();
    issue(5'd5, 5'd0, 1'b1, 32'h3, 4'b0010);
    tick();
    checks++;
    if (src1_o !== 32'hA || src2_o !== 32'h3 || ctrl_o !== 4'b0010 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_load: got %h %h %h %b, want a 3 2 1", src1_o, src2_o, ctrl_o, valid_o);
    end
  endtask

  task automatic test_bypass();
    idle();
    wb_we_i = 1; wb_addr_i = 7; wb_data_i = 32'h1234_5678;
    issue(5'd7, 5'd7, 1'b0, 32'hDEAD_BEEF, 4'b0110);
    tick();
    checks++;
    if (src1_o !== 32'h1234_5678 || src2_o !== 32'h1234_5678 || ctrl_o !== 4'b0110) begin
      errors++;
      $display("FAIL bypass: got %h %h %h, want 12345678 12345678 6", src1_o, src2_o, ctrl_o);
    end
  endtask

  task automatic test_stall();
    idle();
    issue(5'd5, 5'd0, 1'b1, 32'h3, 4'b0010);
    tick();
    for (int c = 0; c < 3; c++) begin
      issue(5'd5, $urandom_range(0, 31), $urandom_range(0, 1), $urandom, $urandom_range(0, 15));
      stall_i = 1;
      wb_we_i = 1; wb_addr_i = 5; wb_data_i = $urandom;
      #1;
      checks++;
      if (ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cyc%0d: got %b, want 0", c, ready_o);
      end
      tick();
      checks++;
      if (src1_o !== 32'hA || src2_o !== 32'h3 || ctrl_o !== 4'b0010 || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got %h %h %h %b, want a 3 2 1", c, src1_o, src2_o, ctrl_o, valid_o);
      end
    end
    idle();
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b, want 1", ready_o);
    end
  endtask

  task automatic test_flush();
    idle();
    issue(5'd7, 5'd5, 1'b0, 32'h0, 4'b0001);
    tick();
    stall_i = 1; flush_i = 1;
    wb_we_i = 1; wb_addr_i = 9; wb_data_i = 32'h0000_0077;
    tick();
    checks++;
    if (src1_o !== 32'h0 || src2_o !== 32'h0 || ctrl_o !== 4'h0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %h %h %h %b, want 0 0 0 0", src1_o, src2_o, ctrl_o, valid_o);
    end
    idle();
    issue(5'd9, 5'd9, 1'b0, 32'h0, 4'b0111);
    tick();
    checks++;
    if (src1_o !== 32'h77 || src2_o !== 32'h77 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_wb_lands: got %h %h %b, want 77 77 1", src1_o, src2_o, valid_o);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    wb_we_i = 1; wb_addr_i = 3; wb_data_i = 32'hCAFE;
    tick();
    idle();
    issue(5'd3, 5'd7, 1'b0, 32'h0, 4'b0010);
    stall_i = 1; flush_i = 1; rst_i = 1;
    wb_we_i = 1; wb_addr_i = 3; wb_data_i = 32'h55;
    tick();
    checks++;
    if (src1_o !== 32'h0 || src2_o !== 32'h0 || ctrl_o !== 4'h0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h %h %h %b, want 0 0 0 0", src1_o, src2_o, ctrl_o, valid_o);
    end
    idle();
    issue(5'd3, 5'd7, 1'b0, 32'h0, 4'b0010);
    tick();
    checks++;
    if (src1_o !== 32'h0 || src2_o !== 32'h0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_regs: got %h %h %b, want 0 0 1", src1_o, src2_o, valid_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_i      = ($urandom_range(0, 49) == 0);
      flush_i    = ($urandom_range(0, 7) == 0);
      stall_i    = ($urandom_range(0, 3) == 0);
      valid_i    = ($urandom_range(0, 3) != 0);
      wb_we_i    = $urandom_range(0, 1);
      wb_addr_i  = $urandom_range(0, 7);
      wb_data_i  = $urandom;
      rs_addr_i  = $urandom_range(0, 7);
      rt_addr_i  = $urandom_range(0, 7);
      alu_src_i  = $urandom_range(0, 1);
      imm_i      = $urandom;
      alu_ctrl_i = $urandom_range(0, 15);
      #1;
      checks++;
      if (ready_o !== !stall_i) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: got %b, want %b", c, ready_o, !stall_i);
      end
      tick();
      checks++;
      if (src1_o !== m_src1 || src2_o !== m_src2 || ctrl_o !== m_ctrl || valid_o !== m_vld) begin
        errors++;
        $display("FAIL rand_out cyc%0d: got %h %h %h %b, want %h %h %h %b",
                 c, src1_o, src2_o, ctrl_o, valid_o, m_src1, m_src2, m_ctrl, m_vld);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_bypass();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
